data_island_scheduler: RTL and testbench

//  Chooses which HDMI data-island packet goes into each 32-pixel packet slot during blanking.

---
 rtl/hdmi_packet_pkg.sv | 28 ++
 rtl/packet_request_flag.sv | 31 +++
 rtl/data_island_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_data_island_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_packet_pkg
//   Shared definitions for the HDMI data-island packet scheduler.
//   - packet_type_t : HB0 codes of the packets the scheduler can emit
//   - sched_state_t : scheduler FSM states
//   - PACKET_LENGTH_DEFAULT / MAX_PACKETS_PER_ISLAND_DEFAULT : slot geometry
// -----------------------------------------------------------------------------
package hdmi_packet_pkg;

   typedef enum logic [7:0] {
      PKT_NULL     = 8'h00,
      PKT_ACR      = 8'h01,
      PKT_AUDIO    = 8'h02,
      PKT_AVI      = 8'h82,
      PKT_SPD      = 8'h83,
      PKT_AUDIO_IF = 8'h84
   } packet_type_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_CLOSE = 2'd2
   } sched_state_t;

   localparam int PACKET_LENGTH_DEFAULT          = 32;
   localparam int MAX_PACKETS_PER_ISLAND_DEFAULT = 18;

endpackage

// File: rtl/packet_request_flag.sv
// -----------------------------------------------------------------------------
// packet_request_flag
//   One pending-request bit. Set and clear are single-cycle strobes; when both
//   arrive in the same cycle the set wins, so a request raised in the very
//   cycle its previous request is granted is not lost.
// Ports:
//   clk     in  clock
//   reset   in  asynchronous active-high reset (clears the flag)
//   set     in  request strobe
//   clear   in  grant strobe
//   pending out flag state
// -----------------------------------------------------------------------------
module packet_request_flag (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clear,
   output logic pending
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
      end else if (set) begin
         pending <= 1'b1;
      end else if (clear) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/data_island_scheduler.sv
// -----------------------------------------------------------------------------
// data_island_scheduler
//   Picks the HDMI data-island packet for each 32-pixel slot during blanking.
//   Fixed priority: ACR > AUDIO > AVI > AUDIO_IF > SPD (SPD only when the
//   SPD_INFOFRAME_EN macro is defined; otherwise no SPD logic exists).
// Ports:
//   clk_pixel              in   pixel clock
//   reset                  in   asynchronous active-high reset
//   island_opportunity     in   blanking has room for a packet plus guard band
//   frame_start            in   first-pixel-of-frame pulse (requests InfoFrames)
//   clk_audio_counter_wrap in   toggle; every edge requests one ACR packet
//   audio_sample_ready     in   audio sample packet available (level)
//   audio_sample_ack       out  pulse: an audio slot was granted
//   packet_enable          out  pulse on the first pixel of each slot
//   packet_type            out  HB0 of the current packet, held for the slot
//   island_active          out  high from first through last slot of an island
// Valid/ready contract: a slot is granted only in an arbitration cycle (IDLE
//   with an opportunity, or the last pixel of a slot); all outputs are
//   registered, so packet_enable/packet_type/audio_sample_ack appear on the
//   cycle after that arbitration cycle and the requester's flag clears there.
// -----------------------------------------------------------------------------
module data_island_scheduler
   import hdmi_packet_pkg::*;
#(
   parameter int PACKET_LENGTH          = PACKET_LENGTH_DEFAULT,
   parameter int MAX_PACKETS_PER_ISLAND = MAX_PACKETS_PER_ISLAND_DEFAULT
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic       island_opportunity,
   input  logic       frame_start,
   input  logic       clk_audio_counter_wrap,
   input  logic       audio_sample_ready,
   output logic       audio_sample_ack,
   output logic       packet_enable,
   output logic [7:0] packet_type,
   output logic       island_active
);

   localparam int SLOT_W = $clog2(PACKET_LENGTH);
   localparam int CNT_W  = $clog2(MAX_PACKETS_PER_ISLAND + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PACKET_LENGTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_PACKETS_PER_ISLAND);

   sched_state_t      state, state_d;
   logic [SLOT_W-1:0] slot_count, slot_count_d;
   logic [CNT_W-1:0]  island_count, island_count_d;
   packet_type_t      type_q, type_d;
   logic              enable_d, ack_d, active_d;

   packet_type_t      winner;
   logic              any_request;
   logic              grant;

   // Request flags
   logic wrap_q;
   logic wrap_edge;
   logic acr_pending, avi_pending, aif_pending;

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= clk_audio_counter_wrap;
      end
   end

   // Either edge of the toggle is one ACR request.
   assign wrap_edge = clk_audio_counter_wrap ^ wrap_q;

   packet_request_flag u_acr_flag (
      .clk     (clk_pixel),
      .reset   (reset),
      .set     (wrap_edge),
      .clear   (grant && (winner == PKT_ACR)),
      .pending (acr_pending)
   );

   packet_request_flag u_avi_flag (
      .clk     (clk_pixel),
      .reset   (reset),
      .set     (frame_start),
      .clear   (grant && (winner == PKT_AVI)),
      .pending (avi_pending)
   );

   packet_request_flag u_aif_flag (
      .clk     (clk_pixel),
      .reset   (reset),
      .set     (frame_start),
      .clear   (grant && (winner == PKT_AUDIO_IF)),
      .pending (aif_pending)
   );

`ifdef SPD_INFOFRAME_EN
   logic spd_pending;

   packet_request_flag u_spd_flag (
      .clk     (clk_pixel),
      .reset   (reset),
      .set     (frame_start),
      .clear   (grant && (winner == PKT_SPD)),
      .pending (spd_pending)
   );
`endif

   // Priority encoder; PKT_NULL means nothing to send.
   always_comb begin
      winner = PKT_NULL;
      if (acr_pending) begin
         winner = PKT_ACR;
      end else if (audio_sample_ready) begin
         winner = PKT_AUDIO;
      end else if (avi_pending) begin
         winner = PKT_AVI;
      end else if (aif_pending) begin
         winner = PKT_AUDIO_IF;
`ifdef SPD_INFOFRAME_EN
      end else if (spd_pending) begin
         winner = PKT_SPD;
`endif
      end
   end

   assign any_request = (winner != PKT_NULL);

   // FSM: next state and next (registered) outputs
   always_comb begin
      state_d        = state;
      slot_count_d   = slot_count;
      island_count_d = island_count;
      type_d         = type_q;
      enable_d       = 1'b0;
      ack_d          = 1'b0;
      active_d       = island_active;
      grant          = 1'b0;

      case (state)
         ST_IDLE: begin
            if (island_opportunity && any_request) begin
               grant          = 1'b1;
               state_d        = ST_SEND;
               slot_count_d   = '0;
               island_count_d = CNT_W'(1);
               enable_d       = 1'b1;
               ack_d          = (winner == PKT_AUDIO);
               type_d         = winner;
               active_d       = 1'b1;
            end
         end
         ST_SEND: begin
            if (slot_count == SLOT_LAST) begin
               // Slot boundary: either chain another packet or close the island.
               if (island_opportunity && any_request && (island_count < CNT_MAX)) begin
                  grant          = 1'b1;
                  slot_count_d   = '0;
                  island_count_d = island_count + 1'b1;
                  enable_d       = 1'b1;
                  ack_d          = (winner == PKT_AUDIO);
                  type_d         = winner;
               end else begin
                  state_d  = ST_CLOSE;
                  type_d   = PKT_NULL;
                  active_d = 1'b0;
               end
            end else begin
               slot_count_d = slot_count + 1'b1;
            end
         end
         ST_CLOSE: begin
            // One island per opportunity: wait for the opportunity to drop.
            type_d   = PKT_NULL;
            active_d = 1'b0;
            if (!island_opportunity) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            type_d   = PKT_NULL;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         slot_count       <= '0;
         island_count     <= '0;
         type_q           <= PKT_NULL;
         packet_enable    <= 1'b0;
         audio_sample_ack <= 1'b0;
         island_active    <= 1'b0;
      end else begin
         state            <= state_d;
         slot_count       <= slot_count_d;
         island_count     <= island_count_d;
         type_q           <= type_d;
         packet_enable    <= enable_d;
         audio_sample_ack <= ack_d;
         island_active    <= active_d;
      end
   end

   assign packet_type = type_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// -----------------------------------------------------------------------------
// tb_data_island_scheduler
//   Directed bench for data_island_scheduler. Stimulus pushes expected slots
//   {packet_type, ack, back_to_back} into exp_q; a monitor pops one entry per
//   packet_enable strobe and checks type, ack, island_active, strobe spacing
//   and that the type is still held on the last pixel of the slot.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_island_scheduler;

   logic       clk_pixel = 1'b0;
   logic       reset = 1'b0;
   logic       island_opportunity = 1'b0;
   logic       frame_start = 1'b0;
   logic       clk_audio_counter_wrap = 1'b0;
   logic       audio_sample_ready = 1'b0;
   logic       audio_sample_ack;
   logic       packet_enable;
   logic [7:0] packet_type;
   logic       island_active;

   logic [9:0] exp_q[$];   // {ptype[7:0], ack, back_to_back}
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   data_island_scheduler dut (
      .clk_pixel              (clk_pixel),
      .reset                  (reset),
      .island_opportunity     (island_opportunity),
      .frame_start            (frame_start),
      .clk_audio_counter_wrap (clk_audio_counter_wrap),
      .audio_sample_ready     (audio_sample_ready),
      .audio_sample_ack       (audio_sample_ack),
      .packet_enable          (packet_enable),
      .packet_type            (packet_type),
      .island_active          (island_active)
   );

   // Clock / cycle counter
   always #5 clk_pixel = ~clk_pixel;
   always @(posedge clk_pixel) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [7:0] ptype, input logic ack, input logic b2b);
      exp_q.push_back({ptype, ack, b2b});
   endtask

   // Monitor / scoreboard
   logic       in_slot = 1'b0;
   int         slot_off = 0;
   int         last_strobe = 0;
   logic [7:0] cur_type = 8'h00;

   always @(negedge clk_pixel) begin
      if (reset) begin
         in_slot = 1'b0;
      end else begin
         if (in_slot) begin
            slot_off++;
            if (slot_off == 31) begin
               check("slot_hold_type", {24'd0, packet_type}, {24'd0, cur_type});
               check("slot_hold_active", {31'd0, island_active}, 32'd1);
               in_slot = 1'b0;
            end
         end
         if (packet_enable) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe actual_type=0x%0h required=no_slot at %0t",
                        packet_type, $time);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               check("strobe_type", {24'd0, packet_type}, {24'd0, e[9:2]});
               check("strobe_ack", {31'd0, audio_sample_ack}, {31'd0, e[1]});
               check("strobe_active", {31'd0, island_active}, 32'd1);
               if (e[0]) check("strobe_spacing", cyc - last_strobe, 32'd32);
               cur_type    = e[9:2];
               last_strobe = cyc;
               slot_off    = 0;
               in_slot     = 1'b1;
            end
         end
      end
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk_pixel);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
      exp_q.delete();
      tick(34);
   endtask

   task automatic wait_acks(input int count, input int budget);
      int got = 0;
      int n = 0;
      while (got < count && n < budget) begin
         tick(1);
         if (audio_sample_ack) got++;
         n++;
      end
      check("ack_wait", got, count);
   endtask

   task automatic wait_strobe(input int budget);
      int n = 0;
      logic seen = 1'b0;
      while (!seen && n < budget) begin
         tick(1);
         seen = packet_enable;
         n++;
      end
      check("strobe_wait", {31'd0, seen}, 32'd1);
   endtask

   task automatic close_opportunity();
      island_opportunity = 1'b0;
      tick(3);
   endtask

   initial begin
      // Reset state
      #2 reset = 1'b1;
      #1;
      check("reset_enable", {31'd0, packet_enable}, 32'd0);
      check("reset_ack", {31'd0, audio_sample_ack}, 32'd0);
      check("reset_active", {31'd0, island_active}, 32'd0);
      check("reset_type", {24'd0, packet_type}, 32'd0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // 1: single ACR toggle -> one ACR slot, then CLOSE
      island_opportunity = 1'b1;
      push_exp(8'h01, 1'b0, 1'b0);
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      wait_drain(100);
      check("t1_close_active", {31'd0, island_active}, 32'd0);
      check("t1_close_type", {24'd0, packet_type}, 32'd0);
      close_opportunity();

      // 2: ACR + audio + frame_start together -> 01,02,02,02,82,84 back to back
      frame_start = 1'b1;
      audio_sample_ready = 1'b1;
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      push_exp(8'h01, 1'b0, 1'b0);
      push_exp(8'h02, 1'b1, 1'b1);
      push_exp(8'h02, 1'b1, 1'b1);
      push_exp(8'h02, 1'b1, 1'b1);
      push_exp(8'h82, 1'b0, 1'b1);
      push_exp(8'h84, 1'b0, 1'b1);
      tick(1);
      frame_start = 1'b0;
      island_opportunity = 1'b1;
      wait_acks(3, 200);
      audio_sample_ready = 1'b0;
      wait_drain(300);
      check("t2_close_active", {31'd0, island_active}, 32'd0);
      close_opportunity();

      // 3: audio held -> 18 slots, island closes, no slot until opportunity re-opens
      audio_sample_ready = 1'b1;
      push_exp(8'h02, 1'b1, 1'b0);
      for (int i = 1; i < 18; i++) push_exp(8'h02, 1'b1, 1'b1);
      island_opportunity = 1'b1;
      wait_drain(800);
      tick(100);
      check("t3_cap_active", {31'd0, island_active}, 32'd0);
      check("t3_cap_type", {24'd0, packet_type}, 32'd0);
      close_opportunity();
      push_exp(8'h02, 1'b1, 1'b0);
      for (int i = 1; i < 7; i++) push_exp(8'h02, 1'b1, 1'b1);
      island_opportunity = 1'b1;
      wait_acks(7, 400);
      audio_sample_ready = 1'b0;
      wait_drain(100);
      check("t3_reopen_close", {31'd0, island_active}, 32'd0);
      close_opportunity();

      // 4: second ACR edge lands on the ACR grant cycle -> two ACR slots
      island_opportunity = 1'b1;
      tick(2);
      push_exp(8'h01, 1'b0, 1'b0);
      push_exp(8'h01, 1'b0, 1'b1);
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      tick(1);
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      wait_drain(200);
      tick(20);
      check("t4_close_active", {31'd0, island_active}, 32'd0);
      close_opportunity();

      // 5: asynchronous reset at slot_count=10 of an AVI slot
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      push_exp(8'h82, 1'b0, 1'b0);
      island_opportunity = 1'b1;
      wait_strobe(20);
      repeat (10) @(posedge clk_pixel);
      #3 reset = 1'b1;
      #1;
      check("t5_rst_enable", {31'd0, packet_enable}, 32'd0);
      check("t5_rst_ack", {31'd0, audio_sample_ack}, 32'd0);
      check("t5_rst_active", {31'd0, island_active}, 32'd0);
      check("t5_rst_type", {24'd0, packet_type}, 32'd0);
      tick(2);
      reset = 1'b0;
      tick(60);   // AUDIO_IF request was cleared: nothing may be sent
      check("t5_post_active", {31'd0, island_active}, 32'd0);
      close_opportunity();

      // 6: single frame_start -> AVI, AUDIO_IF (, SPD)
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      push_exp(8'h82, 1'b0, 1'b0);
      push_exp(8'h84, 1'b0, 1'b1);
`ifdef SPD_INFOFRAME_EN
      push_exp(8'h83, 1'b0, 1'b1);
`endif
      island_opportunity = 1'b1;
      wait_drain(200);
      tick(40);
      check("t6_close_active", {31'd0, island_active}, 32'd0);
      close_opportunity();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
